// File: rtl/sensor_monitor.sv
// Multi-channel sensor fault monitor: per-channel persistence FSM with sticky faults,
// clear handshake and a saturating count of fault-entry events.
module sensor_monitor #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PERSIST = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*NUM_CH-1:0]   sensors,
    input  logic                  clear,
    output logic [NUM_CH-1:0]     fault_mask,
    output logic                  error,
    output logic [CNT_W-1:0]      fault_count,
    output logic                  clear_ack
);

    localparam int unsigned PW    = $clog2(PERSIST + 1);
    localparam int unsigned ENT_W = 5;
    localparam int unsigned SUM_W = CNT_W + ENT_W;
    localparam logic [PW-1:0]    CNT_LAST = PW'(PERSIST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_PENDING = 2'd1,
        ST_FAULT   = 2'd2
    } ch_state_e;

    ch_state_e          state_q [NUM_CH];
    ch_state_e          state_d [NUM_CH];
    logic [PW-1:0]      cnt_q   [NUM_CH];
    logic [PW-1:0]      cnt_d   [NUM_CH];

    logic [NUM_CH-1:0]  raw_c;
    logic [NUM_CH-1:0]  entry_c;
    logic [NUM_CH-1:0]  fault_mask_q, fault_mask_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   fault_count_q, fault_count_d;
    logic               clear_ack_q, clear_ack_d;
    logic [ENT_W-1:0]   n_entry_c;
    logic [SUM_W-1:0]   sum_c;

    // Raw error: primary alone, or secondary confirmed by either backup.
    always_comb begin
        raw_c = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            raw_c[k] = sensors[4*k] | (sensors[4*k+1] & (sensors[4*k+2] | sensors[4*k+3]));
        end
    end

    // Per-channel next state; a fault latched before a clear edge is dropped,
    // while a channel entering fault on that same edge keeps it.
    always_comb begin
        entry_c = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                ST_OK: begin
                    if (enable && raw_c[k]) begin
                        if (PERSIST == 1) begin
                            state_d[k] = ST_FAULT;
                            entry_c[k] = 1'b1;
                        end else begin
                            state_d[k] = ST_PENDING;
                            cnt_d[k]   = PW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (!enable || !raw_c[k]) begin
                        state_d[k] = ST_OK;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = ST_FAULT;
                        cnt_d[k]   = '0;
                        entry_c[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + PW'(1);
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        state_d[k] = ST_OK;
                        cnt_d[k]   = '0;
                    end
                end
                default: begin
                    state_d[k] = ST_OK;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // Output next values: mask mirrors the next channel states; count adds all entries, saturating.
    always_comb begin
        fault_mask_d = '0;
        n_entry_c    = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            fault_mask_d[k] = (state_d[k] == ST_FAULT);
            n_entry_c       = n_entry_c + ENT_W'(entry_c[k]);
        end
        error_d     = |fault_mask_d;
        clear_ack_d = clear;
        sum_c       = SUM_W'(fault_count_q) + SUM_W'(n_entry_c);
        if (sum_c > SUM_W'(CNT_MAX)) begin
            fault_count_d = CNT_MAX;
        end else begin
            fault_count_d = CNT_W'(sum_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                state_q[k] <= ST_OK;
                cnt_q[k]   <= '0;
            end
            fault_mask_q  <= '0;
            error_q       <= 1'b0;
            fault_count_q <= '0;
            clear_ack_q   <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            fault_mask_q  <= fault_mask_d;
            error_q       <= error_d;
            fault_count_q <= fault_count_d;
            clear_ack_q   <= clear_ack_d;
        end
    end

    assign fault_mask  = fault_mask_q;
    assign error       = error_q;
    assign fault_count = fault_count_q;
    assign clear_ack   = clear_ack_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Self-checking bench for sensor_monitor: run-length scoreboard model plus directed scenario checks.
module tb_sensor_monitor;

    localparam int NUM_CH  = 4;
    localparam int PERSIST = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [15:0] sensors;

    logic [3:0]  fault_mask, fault_mask_s;
    logic        error, error_s;
    logic [7:0]  fault_count;
    logic [1:0]  fault_count_s;
    logic        clear_ack, clear_ack_s;

    sensor_monitor #(.NUM_CH(4), .PERSIST(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .clear(clear),
        .fault_mask(fault_mask), .error(error), .fault_count(fault_count), .clear_ack(clear_ack)
    );

    sensor_monitor #(.NUM_CH(4), .PERSIST(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .clear(clear),
        .fault_mask(fault_mask_s), .error(error_s), .fault_count(fault_count_s), .clear_ack(clear_ack_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mask;
        logic       err;
        logic [7:0] cnt;
        logic [1:0] cnt_sat;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bit m_fault [NUM_CH];
    int m_run   [NUM_CH];
    int m_cnt;
    int m_cnt_sat;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_fault[k] = 1'b0;
            m_run[k]   = 0;
        end
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    // Drive one cycle at the falling edge, queue the model's expectation, return 3 units after the edge.
    task automatic cycle(input logic [15:0] s, input logic en, input logic clr);
        exp_t e;
        int   entries;
        logic r;
        entries = 0;
        @(negedge clk);
        sensors = s;
        enable  = en;
        clear   = clr;
        for (int k = 0; k < NUM_CH; k++) begin
            r = s[4*k] | (s[4*k+1] & (s[4*k+2] | s[4*k+3]));
            if (m_fault[k]) begin
                if (clr) begin
                    m_fault[k] = 1'b0;
                    m_run[k]   = 0;
                end
            end else if (!en || !r) begin
                m_run[k] = 0;
            end else begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] >= PERSIST) begin
                    m_fault[k] = 1'b1;
                    m_run[k]   = 0;
                    entries++;
                end
            end
        end
        m_cnt     = (m_cnt + entries > 255) ? 255 : m_cnt + entries;
        m_cnt_sat = (m_cnt_sat + entries > 3) ? 3 : m_cnt_sat + entries;
        for (int k = 0; k < NUM_CH; k++) e.mask[k] = m_fault[k];
        e.err     = |e.mask;
        e.cnt     = 8'(m_cnt);
        e.cnt_sat = 2'(m_cnt_sat);
        e.ack     = clr;
        sb.push_back(e);
        @(posedge clk);
        #3;
    endtask

    // Scoreboard: pop one expectation per active edge and compare both instances.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (fault_mask !== e.mask) begin
                n_errors++;
                $display("FAIL sb_mask t=%0t got=%b exp=%b", $time, fault_mask, e.mask);
            end
            n_checks++;
            if (error !== e.err) begin
                n_errors++;
                $display("FAIL sb_error t=%0t got=%b exp=%b", $time, error, e.err);
            end
            n_checks++;
            if (fault_count !== e.cnt) begin
                n_errors++;
                $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, fault_count, e.cnt);
            end
            n_checks++;
            if (fault_count_s !== e.cnt_sat) begin
                n_errors++;
                $display("FAIL sb_count_sat t=%0t got=%0d exp=%0d", $time, fault_count_s, e.cnt_sat);
            end
            n_checks++;
            if (clear_ack !== e.ack || clear_ack_s !== e.ack) begin
                n_errors++;
                $display("FAIL sb_ack t=%0t got=%b/%b exp=%b", $time, clear_ack, clear_ack_s, e.ack);
            end
        end
    end

    task automatic test_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        clear   = 1'b0;
        sensors = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({fault_mask, error, fault_count, clear_ack} !== 14'd0 ||
            {fault_mask_s, error_s, fault_count_s, clear_ack_s} !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%b/%0d/%b exp=0", fault_mask, fault_count, clear_ack);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_persist();
        cycle(16'h0001, 1'b1, 1'b0);
        cycle(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0000 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL persist_2edges mask=%b err=%b exp=0000/0", fault_mask, error);
        end
        cycle(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0001 || error !== 1'b1 || fault_count !== 8'd1) begin
            n_errors++;
            $display("FAIL persist_3edges mask=%b err=%b cnt=%0d exp=0001/1/1", fault_mask, error, fault_count);
        end
    endtask

    task automatic test_glitch();
        cycle(16'h0061, 1'b1, 1'b0);
        cycle(16'h0061, 1'b1, 1'b0);
        cycle(16'h0001, 1'b1, 1'b0);
        cycle(16'h0061, 1'b1, 1'b0);
        cycle(16'h0061, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0001) begin
            n_errors++;
            $display("FAIL glitch_ch1 mask=%b exp=0001", fault_mask);
        end
        cycle(16'h0001, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        cycle(16'h1A01, 1'b1, 1'b0);
        cycle(16'h1A01, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0001 || fault_count !== 8'd1) begin
            n_errors++;
            $display("FAIL simul_pre mask=%b cnt=%0d exp=0001/1", fault_mask, fault_count);
        end
        cycle(16'h1A01, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b1101 || fault_count !== 8'd3) begin
            n_errors++;
            $display("FAIL simul_entry mask=%b cnt=%0d exp=1101/3", fault_mask, fault_count);
        end
    endtask

    task automatic test_clear();
        cycle(16'h1A01, 1'b1, 1'b1);
        n_checks++;
        if (fault_mask !== 4'b0000 || clear_ack !== 1'b1 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_pulse mask=%b ack=%b err=%b exp=0000/1/0", fault_mask, clear_ack, error);
        end
        cycle(16'h1A01, 1'b1, 1'b0);
        n_checks++;
        if (clear_ack !== 1'b0 || fault_mask !== 4'b0000) begin
            n_errors++;
            $display("FAIL clear_ack_single ack=%b mask=%b exp=0/0000", clear_ack, fault_mask);
        end
        cycle(16'h1A01, 1'b1, 1'b0);
        cycle(16'h1A01, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b1101 || fault_count !== 8'd6) begin
            n_errors++;
            $display("FAIL clear_refault mask=%b cnt=%0d exp=1101/6", fault_mask, fault_count);
        end
    endtask

    task automatic test_enable();
        repeat (3) cycle(16'h0061, 1'b0, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b1101 || fault_count !== 8'd6) begin
            n_errors++;
            $display("FAIL enable_hold mask=%b cnt=%0d exp=1101/6", fault_mask, fault_count);
        end
        cycle(16'h0061, 1'b0, 1'b1);
        n_checks++;
        if (fault_mask !== 4'b0000 || clear_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL enable_clear mask=%b ack=%b exp=0000/1", fault_mask, clear_ack);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) cycle(16'h0060, 1'b1, 1'b0);
        repeat (2) cycle(16'h0061, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0010 || fault_count !== 8'd7) begin
            n_errors++;
            $display("FAIL areset_setup mask=%b cnt=%0d exp=0010/7", fault_mask, fault_count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({fault_mask, error, fault_count, clear_ack} !== 14'd0 || fault_count_s !== 2'd0) begin
            n_errors++;
            $display("FAIL areset_immediate mask=%b err=%b cnt=%0d exp=0", fault_mask, error, fault_count);
        end
        rst = 1'b0;
        model_reset();
        cycle(16'h0001, 1'b1, 1'b0);
        cycle(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0000) begin
            n_errors++;
            $display("FAIL areset_fresh2 mask=%b exp=0000", fault_mask);
        end
        cycle(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (fault_mask !== 4'b0001 || fault_count !== 8'd1) begin
            n_errors++;
            $display("FAIL areset_fresh3 mask=%b cnt=%0d exp=0001/1", fault_mask, fault_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0001, 1'b1, 1'b1);
            repeat (3) cycle(16'h0001, 1'b1, 1'b0);
        end
        n_checks++;
        if (fault_count_s !== 2'd3 || fault_count !== 8'd5) begin
            n_errors++;
            $display("FAIL saturate sat=%0d wide=%0d exp=3/5", fault_count_s, fault_count);
        end
    endtask

    task automatic test_clear_hold();
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0001, 1'b1, 1'b1);
            n_checks++;
            if (clear_ack !== 1'b1) begin
                n_errors++;
                $display("FAIL clear_hold_ack%0d ack=%b exp=1", i, clear_ack);
            end
        end
        n_checks++;
        if (fault_mask !== 4'b0001 || fault_count !== 8'd6) begin
            n_errors++;
            $display("FAIL clear_edge_entry mask=%b cnt=%0d exp=0001/6", fault_mask, fault_count);
        end
        cycle(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (clear_ack !== 1'b0 || fault_mask !== 4'b0001) begin
            n_errors++;
            $display("FAIL clear_hold_release ack=%b mask=%b exp=0/0001", clear_ack, fault_mask);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_persist();
        test_glitch();
        test_simultaneous();
        test_clear();
        test_enable();
        test_async_reset();
        test_saturate();
        test_clear_hold();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
